// File: rtl/store_stream_guard.sv
`default_nettype none
// ============================================================================
// store_stream_guard : follows contiguous store streams, keeps long ones as
// overflow ranges, and flags an indirect jump that follows a load into one.
// Revision: 1.0
// ============================================================================

module store_stream_guard #(
    parameter int NR_STREAMS = 4,
    parameter int REC_DEPTH  = 8,
    parameter int ADDR_W     = 32,
    parameter int MIN_SPAN   = 32,
    parameter int TIMEOUT    = 10
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         crash_en_i,
    input  logic                         valid_i,
    input  logic [1:0]                   op_i,
    input  logic [2:0]                   size_i,
    input  logic [ADDR_W-1:0]            addr_i,
    input  logic                         skip_i,
    output logic                         hit_o,
    output logic                         crash_o,
    output logic                         rec_wr_o,
    output logic [$clog2(REC_DEPTH):0]   rec_count_o
);

    localparam int SIDX_W = (NR_STREAMS > 1) ? $clog2(NR_STREAMS) : 1;
    localparam int PTR_W  = (REC_DEPTH > 1) ? $clog2(REC_DEPTH) : 1;
    localparam int RCNT_W = $clog2(REC_DEPTH) + 1;
    localparam int SCNT_W = 16;
    localparam int AGE_W  = 4;
    localparam logic [SCNT_W-1:0] MIN_SPAN_C = SCNT_W'(MIN_SPAN);
    localparam logic [AGE_W-1:0]  TIMEOUT_C  = AGE_W'(TIMEOUT);
    localparam logic [RCNT_W-1:0] REC_FULL_C = RCNT_W'(REC_DEPTH);

    logic [NR_STREAMS-1:0] active_q, active_d;
    logic [ADDR_W-1:0]     start_q [NR_STREAMS], start_d [NR_STREAMS];
    logic [ADDR_W-1:0]     last_addr_q [NR_STREAMS], last_addr_d [NR_STREAMS];
    logic [2:0]            last_size_q [NR_STREAMS], last_size_d [NR_STREAMS];
    logic [SCNT_W-1:0]     count_q [NR_STREAMS], count_d [NR_STREAMS];
    logic [AGE_W-1:0]      age_q [NR_STREAMS], age_d [NR_STREAMS];
    logic [REC_DEPTH-1:0]  rec_valid_q, rec_valid_d;
    logic [ADDR_W-1:0]     rec_lo_q [REC_DEPTH], rec_lo_d [REC_DEPTH];
    logic [ADDR_W:0]       rec_hi_q [REC_DEPTH], rec_hi_d [REC_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [RCNT_W-1:0]     rec_count_q, rec_count_d;
    logic                  taint_q, taint_d, hit_q, hit_d;
    logic                  crash_q, crash_d, rec_wr_q, rec_wr_d;

    logic [ADDR_W:0]       end_w [NR_STREAMS];
    logic [ADDR_W:0]       hi_w [NR_STREAMS];
    logic [NR_STREAMS-1:0] match_v, stream_hit;
    logic [REC_DEPTH-1:0]  rec_hit;
    logic                  is_store, is_load, is_jump, upd_match;
    logic                  match_found, free_found, to_found, do_evict, close_valid;
    logic [SIDX_W-1:0]     match_idx, free_idx, to_idx, evict_idx, alloc_idx, close_idx;
    logic [AGE_W-1:0]      evict_age;
    logic [SCNT_W:0]       count_sum;

    assign is_store = valid_i && (op_i == 2'd1) && !skip_i;
    assign is_load  = valid_i && (op_i == 2'd2);
    assign is_jump  = valid_i && (op_i == 2'd3);

    // end_w keeps the carry so a stream ending at the top of memory never matches
    for (genvar gi = 0; gi < NR_STREAMS; gi++) begin : g_stream
        assign end_w[gi]      = {1'b0, last_addr_q[gi]} + {{(ADDR_W-2){1'b0}}, last_size_q[gi]};
        assign hi_w[gi]       = end_w[gi] - {{ADDR_W{1'b0}}, 1'b1};
        assign match_v[gi]    = active_q[gi] && !end_w[gi][ADDR_W]
                                && (end_w[gi][ADDR_W-1:0] == addr_i);
        assign stream_hit[gi] = active_q[gi] && (addr_i >= start_q[gi])
                                && ({1'b0, addr_i} <= hi_w[gi]);
    end

    for (genvar gj = 0; gj < REC_DEPTH; gj++) begin : g_rec
        assign rec_hit[gj] = rec_valid_q[gj] && (addr_i >= rec_lo_q[gj])
                             && ({1'b0, addr_i} <= rec_hi_q[gj]);
    end

    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = NR_STREAMS - 1; i >= 0; i--) begin
            if (match_v[i]) begin
                match_found = 1'b1;
                match_idx   = SIDX_W'(i);
            end
            if (!active_q[i]) begin
                free_found = 1'b1;
                free_idx   = SIDX_W'(i);
            end
        end
        // the stream being extended this cycle is not a timeout candidate
        to_found = 1'b0;
        to_idx   = '0;
        for (int i = NR_STREAMS - 1; i >= 0; i--) begin
            if (active_q[i] && (age_q[i] == '0)
                && !(is_store && match_found && (match_idx == SIDX_W'(i)))) begin
                to_found = 1'b1;
                to_idx   = SIDX_W'(i);
            end
        end
        evict_idx = '0;
        evict_age = age_q[0];
        for (int i = 1; i < NR_STREAMS; i++) begin
            if (age_q[i] < evict_age) begin
                evict_age = age_q[i];
                evict_idx = SIDX_W'(i);
            end
        end
    end

    assign upd_match   = is_store && match_found;
    assign do_evict    = is_store && !match_found && !free_found;
    assign alloc_idx   = free_found ? free_idx : evict_idx;
    assign close_valid = do_evict || to_found;
    assign close_idx   = do_evict ? evict_idx : to_idx;

    always_comb begin
        active_d    = active_q;
        start_d     = start_q;
        last_addr_d = last_addr_q;
        last_size_d = last_size_q;
        count_d     = count_q;
        age_d       = age_q;
        rec_valid_d = rec_valid_q;
        rec_lo_d    = rec_lo_q;
        rec_hi_d    = rec_hi_q;
        wr_ptr_d    = wr_ptr_q;
        rec_count_d = rec_count_q;
        taint_d     = taint_q;
        hit_d       = 1'b0;
        crash_d     = 1'b0;
        rec_wr_d    = 1'b0;
        count_sum   = '0;

        if (valid_i) begin
            for (int i = 0; i < NR_STREAMS; i++) begin
                if (active_q[i] && !(upd_match && (match_idx == SIDX_W'(i))) && (age_q[i] != '0))
                    age_d[i] = age_q[i] - AGE_W'(1);
            end
        end

        if (close_valid) begin
            active_d[close_idx] = 1'b0;
            if (count_q[close_idx] >= MIN_SPAN_C) begin
                rec_valid_d[wr_ptr_q] = 1'b1;
                rec_lo_d[wr_ptr_q]    = start_q[close_idx];
                rec_hi_d[wr_ptr_q]    = hi_w[close_idx];
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
                rec_wr_d              = 1'b1;
                if (rec_count_q != REC_FULL_C)
                    rec_count_d = rec_count_q + RCNT_W'(1);
            end
        end

        // allocation runs after the close so an evicted slot is reused at once
        if (is_store) begin
            if (match_found) begin
                count_sum              = {1'b0, count_q[match_idx]} + {{(SCNT_W-2){1'b0}}, size_i};
                last_addr_d[match_idx] = addr_i;
                last_size_d[match_idx] = size_i;
                count_d[match_idx]     = count_sum[SCNT_W] ? '1 : count_sum[SCNT_W-1:0];
                age_d[match_idx]       = TIMEOUT_C;
            end else begin
                active_d[alloc_idx]    = 1'b1;
                start_d[alloc_idx]     = addr_i;
                last_addr_d[alloc_idx] = addr_i;
                last_size_d[alloc_idx] = size_i;
                count_d[alloc_idx]     = {{(SCNT_W-3){1'b0}}, size_i};
                age_d[alloc_idx]       = TIMEOUT_C;
            end
        end

        if (is_load) begin
            hit_d   = (|stream_hit) || (|rec_hit);
            taint_d = hit_d;
        end
        if (is_jump) begin
            crash_d = taint_q && crash_en_i;
            taint_d = 1'b0;
        end

        if (flush_i) begin
            active_d    = '0;
            rec_valid_d = '0;
            wr_ptr_d    = '0;
            rec_count_d = '0;
            taint_d     = 1'b0;
            hit_d       = 1'b0;
            crash_d     = 1'b0;
            rec_wr_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q    <= '0;
            rec_valid_q <= '0;
            wr_ptr_q    <= '0;
            rec_count_q <= '0;
            taint_q     <= 1'b0;
            hit_q       <= 1'b0;
            crash_q     <= 1'b0;
            rec_wr_q    <= 1'b0;
            for (int i = 0; i < NR_STREAMS; i++) begin
                start_q[i]     <= '0;
                last_addr_q[i] <= '0;
                last_size_q[i] <= '0;
                count_q[i]     <= '0;
                age_q[i]       <= '0;
            end
            for (int j = 0; j < REC_DEPTH; j++) begin
                rec_lo_q[j] <= '0;
                rec_hi_q[j] <= '0;
            end
        end else begin
            active_q    <= active_d;
            rec_valid_q <= rec_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rec_count_q <= rec_count_d;
            taint_q     <= taint_d;
            hit_q       <= hit_d;
            crash_q     <= crash_d;
            rec_wr_q    <= rec_wr_d;
            for (int i = 0; i < NR_STREAMS; i++) begin
                start_q[i]     <= start_d[i];
                last_addr_q[i] <= last_addr_d[i];
                last_size_q[i] <= last_size_d[i];
                count_q[i]     <= count_d[i];
                age_q[i]       <= age_d[i];
            end
            for (int j = 0; j < REC_DEPTH; j++) begin
                rec_lo_q[j] <= rec_lo_d[j];
                rec_hi_q[j] <= rec_hi_d[j];
            end
        end
    end

    assign hit_o       = hit_q;
    assign crash_o     = crash_q;
    assign rec_wr_o    = rec_wr_q;
    assign rec_count_o = rec_count_q;

endmodule

`default_nettype wire
